tdm_demux2: RTL and testbench
=============================

# tdm_demux2

Two-channel time-division demultiplexer and deserializer: the receive end of a link where a 2:1 mux alternates two channel bits onto one serial line. A frame marker identifies slot 0. The block steers each accepted slot to channel 0 or channel 1, assembles WIDTH-bit words per channel, and presents each completed word with a one-cycle valid strobe. It sits between the serial line and the consumer logic, and it tracks frame lock and reports framing errors.

## Interface
- WIDTH, 4: bits per channel word, with WIDTH ≥ 2; a frame is 2*WIDTH slots.
- clk  input  1  system clock; every state change happens on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  slot strobe; d and sync are sampled only when en=1.
- d  input  1  serial data bit for the current slot.
- sync  input  1  frame marker; it is asserted on slot 0 of every frame.
- q0  output  WIDTH  last completed channel-0 word (registered).
- q1  output  WIDTH  last completed channel-1 word (registered).
- valid0  output  1  one-cycle pulse when q0 updates.
- valid1  output  1  one-cycle pulse when q1 updates.
- locked  output  1  high while in LOCKED.
- err  output  1  one-cycle pulse on a framing error.

## Operation
- **Reset.** The reset values are:
  - q0 = q1 = 0, valid0 = valid1 = err = 0, locked = 0.
  - State = HUNT, slot counter = 0, shift registers cleared.
  - rst overrides every other input in the same cycle.
- **Slot counter.** slot runs 0..2*WIDTH-1.
  - Channel = slot[0]: even slots are channel 0, odd slots are channel 1.
  - Bit index = slot >> 1, filled LSB first.
  - The counter wraps from 2*WIDTH-1 to 0.
- **Idle cycles.** Cycles with en=0 change nothing. sync with en=0 is ignored.
- **HUNT.** Accepted slots with sync=0 are discarded. An accepted slot with sync=1 does all of the following:
  - It is taken as slot 0: d is stored as channel-0 bit 0.
  - slot becomes 1 and the state moves to LOCKED.
- **LOCKED.** Each accepted slot writes d into the shift register of its channel, then slot increments.
  - At slot 2*WIDTH-2, q0 loads the full channel-0 word and valid0 pulses.
  - At slot 2*WIDTH-1, q1 loads the full channel-1 word and valid1 pulses.
- **Framing checks in LOCKED.**
  - sync=1 at slot 0 is the normal case; no error.
  - sync=1 at any slot ≠ 0: err pulses and partial words are discarded. The current bit is taken as the new slot 0 (channel-0 bit 0), slot becomes 1, and the state stays LOCKED.
  - sync=0 at slot 0: err pulses, the bit is discarded, the state goes to HUNT and slot resets to 0.
- **Output retention.** q0 and q1 hold their values until the next completion; partial frames never change them.
- **Reset mid-frame.** Partial words are lost and all outputs return to their reset values on the next edge.

## Timing
- All outputs are registered.
- Word latency: the channel word is visible, with its valid pulse, in the cycle after the edge that accepts its last slot.
  - Channel 0 completes at slot 2*WIDTH-2, channel 1 at slot 2*WIDTH-1.
  - The two completions are one accepted slot apart, so valid0 and valid1 are never high together.
- err is high for exactly the one cycle after the offending slot is accepted.
- locked changes on the same edge as the state transition.
- Back-to-back frames need no gap. en may be held high continuously or toggled arbitrarily; only accepted slots count.

## Test plan
With WIDTH=4 throughout:

1. **Single frame.** Reset, then en=1 with sync=1 on the first slot and d = 0,1,1,0,0,1,1,0 over slots 0..7.
   - q0 = 0xA with valid0 pulse after slot 6.
   - q1 = 0x5 with valid1 pulse after slot 7.
   - locked = 1 from the first slot onward; err never asserts.
2. **Gapped stream.** Same frame as test 1, with en=0 cycles inserted between every slot and sync/d toggled during those gaps.
   - Identical q0/q1 values; pulses delayed by the gap cycles only.
3. **Early sync.** While locked, sync=1 at slot 3.
   - err pulses; partial words are dropped; q0/q1 keep their prior values.
   - The next 8 slots decode as a fresh frame starting from that bit.
4. **Missing sync.** While locked, sync=0 at the frame boundary.
   - err pulses; locked = 0; following bits are ignored until sync=1.
   - The next frame then decodes correctly.
5. **Reset mid-frame.** rst=1 at slot 5.
   - The next cycle shows all outputs 0 and locked = 0.
   - A following sync frame decodes normally.
6. **Continuous frames.** Two consecutive frames, 0xA/0x5 then 0x3/0xC.
   - valid0 and valid1 alternate each frame; q0 goes 0xA→0x3 and q1 goes 0x5→0xC; err = 0 throughout.

Source files
------------

// File: rtl/tdm_demux2.sv
// Receive side of a two-channel TDM link: hunts for the frame marker, steers
// alternating slots into per-channel shift registers and emits completed words.
module tdm_demux2 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             d,
   input  logic             sync,
   output logic [WIDTH-1:0] q0,
   output logic [WIDTH-1:0] q1,
   output logic             valid0,
   output logic             valid1,
   output logic             locked,
   output logic             err
);

   localparam int SLOTS = 2 * WIDTH;
   localparam int SW    = $clog2(SLOTS);
   localparam int BW    = SW - 1;
   localparam logic [SW-1:0] LAST0 = SW'(SLOTS - 2);
   localparam logic [SW-1:0] LAST1 = SW'(SLOTS - 1);

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t           state_q;
   logic [SW-1:0]    slot_q;
   logic [WIDTH-1:0] sh0_q, sh1_q;
   logic [WIDTH-1:0] sh0_d, sh1_d;
   logic [BW-1:0]    bit_idx;
   logic             chan;

   assign chan    = slot_q[0];
   assign bit_idx = slot_q[SW-1:1];

   // Shift registers with the current slot's bit already written in place,
   // so a completing slot can load its full word in the same edge.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bits
         assign sh0_d[gi] = (!chan && (bit_idx == BW'(gi))) ? d : sh0_q[gi];
         assign sh1_d[gi] = ( chan && (bit_idx == BW'(gi))) ? d : sh1_q[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HUNT;
         slot_q  <= '0;
         sh0_q   <= '0;
         sh1_q   <= '0;
         q0      <= '0;
         q1      <= '0;
         valid0  <= 1'b0;
         valid1  <= 1'b0;
         locked  <= 1'b0;
         err     <= 1'b0;
      end else begin
         valid0 <= 1'b0;
         valid1 <= 1'b0;
         err    <= 1'b0;
         if (en) begin
            case (state_q)
               HUNT: begin
                  if (sync) begin
                     sh0_q   <= {{(WIDTH-1){1'b0}}, d};
                     sh1_q   <= '0;
                     slot_q  <= SW'(1);
                     state_q <= LOCKED;
                     locked  <= 1'b1;
                  end
               end
               LOCKED: begin
                  if (slot_q == '0) begin
                     if (sync) begin
                        sh0_q  <= {{(WIDTH-1){1'b0}}, d};
                        sh1_q  <= '0;
                        slot_q <= SW'(1);
                     end else begin
                        // Lost the marker at the boundary: drop lock and hunt again.
                        err     <= 1'b1;
                        state_q <= HUNT;
                        locked  <= 1'b0;
                        slot_q  <= '0;
                     end
                  end else if (sync) begin
                     // Marker arrived early: resynchronise on this bit as slot 0.
                     err    <= 1'b1;
                     sh0_q  <= {{(WIDTH-1){1'b0}}, d};
                     sh1_q  <= '0;
                     slot_q <= SW'(1);
                  end else begin
                     sh0_q <= sh0_d;
                     sh1_q <= sh1_d;
                     if (slot_q == LAST0) begin
                        q0     <= sh0_d;
                        valid0 <= 1'b1;
                     end
                     if (slot_q == LAST1) begin
                        q1     <= sh1_d;
                        valid1 <= 1'b1;
                        slot_q <= '0;
                     end else begin
                        slot_q <= slot_q + 1'b1;
                     end
                  end
               end
               default: begin
                  state_q <= HUNT;
                  locked  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux2.sv
// Scoreboard bench for tdm_demux2 (WIDTH=4): expected words are queued as
// frames are driven and checked whenever a valid strobe appears.
module tb_tdm_demux2;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       d;
   logic       sync;
   logic [3:0] q0, q1;
   logic       valid0, valid1, locked, err;

   int n_checks = 0;
   int n_fail   = 0;
   int err_seen = 0;
   int err_exp  = 0;
   logic [3:0] exp0_q[$];
   logic [3:0] exp1_q[$];
   logic [3:0] last0, last1;

   tdm_demux2 #(.WIDTH(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .d      (d),
      .sync   (sync),
      .q0     (q0),
      .q1     (q1),
      .valid0 (valid0),
      .valid1 (valid1),
      .locked (locked),
      .err    (err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Output monitor: runs on the falling edge, away from the active edge.
   always @(negedge clk) begin
      logic [3:0] e;
      if (valid0) begin
         $display("ch0 word 0x%h at %0t", q0, $time);
         check_val("q0_pending", 32'(exp0_q.size() != 0), 1);
         if (exp0_q.size() != 0) begin
            e = exp0_q.pop_front();
            check_val("q0_word", q0, e);
         end
      end
      if (valid1) begin
         $display("ch1 word 0x%h at %0t", q1, $time);
         check_val("q1_pending", 32'(exp1_q.size() != 0), 1);
         if (exp1_q.size() != 0) begin
            e = exp1_q.pop_front();
            check_val("q1_word", q1, e);
         end
      end
      if (valid0 || valid1)
         check_val("valid_overlap", valid0 & valid1, 0);
      if (err)
         err_seen++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_slot(input logic dd, input logic ss);
      en   = 1'b1;
      d    = dd;
      sync = ss;
      tick();
      en   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         d    = 1'($urandom);
         sync = 1'($urandom);
         tick();
      end
      d    = 1'b0;
      sync = 1'b0;
   endtask

   task automatic send_frame(input logic [3:0] w0, input logic [3:0] w1,
                             input int gap, input logic exp_err0);
      logic dd;
      exp0_q.push_back(w0);
      exp1_q.push_back(w1);
      if (exp_err0) err_exp++;
      for (int s = 0; s < 8; s++) begin
         dd = s[0] ? w1[s >> 1] : w0[s >> 1];
         drive_slot(dd, s == 0);
         check_val("valid0_timing", valid0, s == 6);
         check_val("valid1_timing", valid1, s == 7);
         check_val("err_timing", err, (s == 0) ? exp_err0 : 1'b0);
         check_val("locked", locked, 1);
         if (s == 0) begin
            check_val("q0_retained", q0, last0);
            check_val("q1_retained", q1, last1);
         end
         idle(gap);
      end
      last0 = w0;
      last1 = w1;
   endtask

   initial begin
      rst  = 1'b1;
      en   = 1'b0;
      d    = 1'b0;
      sync = 1'b0;
      last0 = 4'h0;
      last1 = 4'h0;
      repeat (3) tick();
      check_val("rst_q0", q0, 0);
      check_val("rst_q1", q1, 0);
      check_val("rst_valid0", valid0, 0);
      check_val("rst_valid1", valid1, 0);
      check_val("rst_err", err, 0);
      check_val("rst_locked", locked, 0);
      rst = 1'b0;
      tick();

      // Single frame, then the same frame with gaps of en=0 between slots.
      send_frame(4'hA, 4'h5, 0, 1'b0);
      send_frame(4'hA, 4'h5, 2, 1'b0);

      // Early sync at slot 3 restarts the frame on that bit.
      drive_slot(1'b1, 1'b1);
      drive_slot(1'b0, 1'b0);
      drive_slot(1'b1, 1'b0);
      check_val("partial_no_err", err, 0);
      send_frame(4'h6, 4'h9, 0, 1'b1);

      // Missing sync at the frame boundary drops lock.
      drive_slot(1'b1, 1'b0);
      err_exp++;
      check_val("miss_err", err, 1);
      check_val("miss_locked", locked, 0);
      for (int i = 0; i < 5; i++) begin
         drive_slot(1'($urandom), 1'b0);
         check_val("hunt_locked", locked, 0);
      end
      send_frame(4'h3, 4'hC, 0, 1'b0);

      // Reset in the middle of a frame.
      for (int s = 0; s < 5; s++) begin
         logic [3:0] a, b;
         a = 4'hA;
         b = 4'h5;
         drive_slot(s[0] ? b[s >> 1] : a[s >> 1], s == 0);
      end
      rst  = 1'b1;
      en   = 1'b1;
      d    = 1'b1;
      sync = 1'b0;
      tick();
      rst  = 1'b0;
      en   = 1'b0;
      check_val("mid_rst_q0", q0, 0);
      check_val("mid_rst_q1", q1, 0);
      check_val("mid_rst_valid0", valid0, 0);
      check_val("mid_rst_valid1", valid1, 0);
      check_val("mid_rst_err", err, 0);
      check_val("mid_rst_locked", locked, 0);
      last0 = 4'h0;
      last1 = 4'h0;
      send_frame(4'hA, 4'h5, 0, 1'b0);

      // Continuous back-to-back frames.
      send_frame(4'hA, 4'h5, 0, 1'b0);
      send_frame(4'h3, 4'hC, 0, 1'b0);

      repeat (3) tick();
      check_val("exp0_drained", exp0_q.size(), 0);
      check_val("exp1_drained", exp1_q.size(), 0);
      check_val("err_count", err_seen, err_exp);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
